sram22_req_ctrl: RTL and testbench

SRAM22_REQ_CTRL -- requirements
Module: sram22_req_ctrl

---
 rtl/sram22_req_ctrl.sv | 133 +++++++++++++
 tb/tb_sram22_req_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_req_ctrl.sv
// Request controller for a single-port SRAM macro: zero-fills the array after reset,
// then forwards requests and queues read data in a small response FIFO.
module sram22_req_ctrl #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 24,
  parameter int WMASK_WIDTH = 3,
  parameter int RSP_DEPTH   = 2,
  parameter int INIT_EN     = 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   init_done,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  // one extra bit so count + pending never wraps
  localparam int CNT_W = $clog2(RSP_DEPTH + 1) + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  icnt_q, icnt_d;
  logic                   init_done_q, init_done_d;
  logic                   pend_q, pend_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0]  fifo_q [RSP_DEPTH];

  logic                   acc, push, pop;
  logic [CNT_W-1:0]       occ;

  assign sram_rstb = rstb;
  assign init_done = init_done_q;
  assign rsp_valid = (cnt_q != '0);
  assign rsp_rdata = fifo_q[rptr_q];

  assign push = pend_q;
  assign pop  = rsp_valid && rsp_ready;
  // slots already spoken for: queued entries plus the read in flight, less what leaves now
  assign occ  = cnt_q + CNT_W'(pend_q) - CNT_W'(pop);

  assign req_ready = rstb && (state_q == ST_RUN) && (occ < CNT_W'(RSP_DEPTH));
  assign acc       = req_valid && req_ready;

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (state_q == ST_INIT) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_wmask = '1;
      sram_addr  = icnt_q;
      sram_din   = '0;
    end else begin
      sram_ce    = acc;
      sram_we    = req_we;
      sram_wmask = req_wmask;
      sram_addr  = req_addr;
      sram_din   = req_wdata;
    end
    if (!rstb) sram_ce = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      icnt_d = icnt_q + 1'b1;
      if (icnt_q == '1) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else if (INIT_EN == 0) begin
      // nothing to fill, so report ready one cycle into RUN
      init_done_d = 1'b1;
    end
  end

  always_comb begin
    pend_d = acc && !req_we;
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = (wptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      icnt_q      <= '0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // data storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (rstb && push) fifo_q[wptr_q] <= sram_dout;
  end

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Scoreboard bench for sram22_req_ctrl: a behavioural SRAM macro, a reference memory
// and an expected-response queue checked by a negedge monitor.
module tb_sram22_req_ctrl;
  localparam int AW = 6, DW = 24, MW = 3, DEPTH = 2;

  logic          clk = 1'b0, rstb = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [MW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          init_done, sram_rstb, sram_ce, sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  sram22_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW),
                    .RSP_DEPTH(DEPTH), .INIT_EN(1)) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .sram_rstb(sram_rstb), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SRAM macro: masked writes, registered read data; seeded with garbage so zero-fill matters
  logic [DW-1:0] mac [2**AW];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 2**AW; i++) mac[i] <= DW'($urandom);
      seeded <= 1'b1;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask[b]) mac[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mac[sram_addr];
      end
    end
  end

  // Reference: memory contents after the zero-fill, and outstanding reads in order
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  logic          mon_en = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int            m_sz;
  logic          m_pop, m_rv;

  always @(negedge clk) begin
    if (!mon_en) begin
      stall_prev = 1'b0;
      exp_q.delete();
      acc_q.delete();
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    end else begin
      m_sz  = exp_q.size();
      m_pop = rsp_valid && rsp_ready;
      m_rv  = (m_sz > 0) ? (acc_q[0] + 2 <= cyc) : 1'b0;
      chk("rsp_valid", rsp_valid, m_rv);
      chk("req_ready", req_ready, (m_sz - int'(m_pop)) < DEPTH);
      chk("sram_ce", sram_ce, req_valid && req_ready);
      if (stall_prev && rsp_valid) chk("rdata_hold", rsp_rdata, stall_data);
      if (m_pop) begin
        chk("rsp_has_entry", m_sz > 0, 1);
        if (m_sz > 0) begin
          chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      stall_data = rsp_rdata;
      if (req_valid && req_ready) begin
        if (req_we) begin
          for (int b = 0; b < MW; b++)
            if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
          acc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic run_init();
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (init_done) break;
      chk("init_wr", {sram_ce, sram_we, sram_wmask, sram_din == '0, req_ready, sram_addr},
                     {1'b1, 1'b1, 3'b111, 1'b1, 1'b0, AW'(n)});
      n++;
    end
    chk("init_cnt", n, 64);
    chk("init_done", init_done, 1);
  endtask

  // hold a request until accepted; returns at the negedge of the accepting cycle
  task automatic send(input bit we, input logic [MW-1:0] m, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int waited);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    waited = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) return;
      waited++;
    end
    chk("send_timeout", req_ready, 1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  int w;

  initial begin
    // reset state with a request present
    rstb = 1'b0; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ce", sram_ce, 0);
    chk("rst_sram_rstb", sram_rstb, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_init_done", init_done, 0);
    @(posedge clk); #1;
    rstb = 1'b1; req_valid = 1'b0;
    run_init();
    mon_en = 1'b1;

    // read after zero-fill
    rsp_ready = 1'b1;
    send(1'b0, '0, 6'd17, '0, w);
    idle(4);

    // masked overwrite
    send(1'b1, 3'b111, 6'd5, 24'hABCDEF, w);
    send(1'b1, 3'b010, 6'd5, 24'h112233, w);
    send(1'b0, '0, 6'd5, '0, w);
    idle(4);

    // back-to-back reads
    for (int a = 0; a < 8; a++) begin
      send(1'b0, '0, AW'(a), '0, w);
      chk("b2b_stall", w, 0);
    end
    idle(5);

    // backpressure: third read waits for the first pop
    rsp_ready = 1'b0;
    send(1'b0, '0, 6'd1, '0, w);
    send(1'b0, '0, 6'd5, '0, w);
    fork
      send(1'b0, '0, 6'd17, '0, w);
      begin repeat (5) @(posedge clk); #1; rsp_ready = 1'b1; end
    join
    chk("r3_with_pop", rsp_valid && rsp_ready, 1);
    chk("r3_waited", w > 0, 1);
    idle(5);

    // random traffic over a small address window
    repeat (400) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_wmask = MW'($urandom);
      req_addr  = AW'($urandom_range(0, 7));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drained", exp_q.size(), 0);

    // reset with one response queued and one read in flight
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1'b0, '0, 6'd3, '0, w);
    send(1'b0, '0, 6'd4, '0, w);
    @(posedge clk); #1;
    rstb = 1'b0; mon_en = 1'b0; req_valid = 1'b1; req_we = 1'b0;
    @(negedge clk);
    chk("midrst_ce", sram_ce, 0);
    chk("midrst_sram_rstb", sram_rstb, 0);
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_ce2", sram_ce, 0);
    chk("midrst_init_done", init_done, 0);
    @(posedge clk); #1;
    rstb = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    run_init();
    mon_en = 1'b1;
    repeat (10) @(posedge clk);
    send(1'b0, '0, 6'd3, '0, w);
    idle(5);
    @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
